// File: rtl/e_pkg.sv
// rtl/e_pkg.sv - shared widths and types for the circular search and slot allocator
package e_pkg;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int DEF_W = 32;

   typedef logic [$clog2(DEF_W)-1:0] slot_t;
   typedef logic [cnt_w(DEF_W)-1:0]  cnt_t;

endpackage

// File: rtl/e.sv
// rtl/e.sv - circular find-first-zero search, descending from pos_i-1 with wrap to W-1
module e #(
   parameter int W       = 32,
   parameter int RADIX_N = 4
) (
   input  logic [W-1:0]         x_i,
   input  logic [$clog2(W)-1:0] pos_i,
   output logic                 any_o,
   output logic [$clog2(W)-1:0] y_enc_o
);

   localparam int IW = $clog2(W);
   localparam int NG = (W + RADIX_N - 1) / RADIX_N;

   logic [NG*RADIX_N-1:0] free_ord;
   logic [NG-1:0]         grp_any;
   logic [IW-1:0]         idx;
   int                    sel_g;
   int                    sel_j;
   int                    off;

   // free_ord[k] is the free flag of the k-th slot visited; first set bit wins
   always_comb begin
      free_ord = '0;
      idx      = '0;
      for (int k = 0; k < W; k++) begin
         idx         = pos_i - IW'(k + 1);
         free_ord[k] = ~x_i[idx];
      end

      grp_any = '0;
      for (int g = 0; g < NG; g++) begin
         grp_any[g] = |free_ord[g*RADIX_N +: RADIX_N];
      end

      sel_g = 0;
      for (int g = NG - 1; g >= 0; g--) begin
         if (grp_any[g]) sel_g = g;
      end

      sel_j = 0;
      for (int j = RADIX_N - 1; j >= 0; j--) begin
         if (free_ord[sel_g*RADIX_N + j]) sel_j = j;
      end

      off     = sel_g * RADIX_N + sel_j;
      any_o   = |grp_any;
      y_enc_o = pos_i - IW'(off + 1);
   end

endmodule

// File: rtl/e_alloc.sv
// rtl/e_alloc.sv - round-robin slot allocator with valid/ready offer and free port
module e_alloc
   import e_pkg::*;
#(
   parameter int W       = 32,
   parameter int RADIX_N = 4
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   clr_i,
   output logic                   alloc_vld_o,
   output logic [$clog2(W)-1:0]   alloc_id_o,
   input  logic                   alloc_rdy_i,
   input  logic                   free_vld_i,
   input  logic [$clog2(W)-1:0]   free_id_i,
   output logic [W-1:0]           occ_o,
   output logic [$clog2(W+1)-1:0] cnt_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   err_o
);

   localparam int IW = $clog2(W);
   localparam int CW = cnt_w(W);

   logic [W-1:0]  occ_q, occ_d;
   logic [IW-1:0] pos_q, pos_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic fire;
   logic legal_free;
   logic illegal_free;

   e #(
      .W       (W),
      .RADIX_N (RADIX_N)
   ) u_e (
      .x_i     (occ_q),
      .pos_i   (pos_q),
      .any_o   (alloc_vld_o),
      .y_enc_o (alloc_id_o)
   );

   // the offered slot is always free, so freeing it lands in the illegal path
   always_comb begin
      fire         = alloc_vld_o & alloc_rdy_i;
      legal_free   = free_vld_i & occ_q[free_id_i];
      illegal_free = free_vld_i & ~occ_q[free_id_i];

      occ_d = occ_q;
      pos_d = pos_q;
      if (fire) begin
         occ_d[alloc_id_o] = 1'b1;
         pos_d             = alloc_id_o;
      end
      if (legal_free) occ_d[free_id_i] = 1'b0;
      cnt_d = cnt_q + CW'(fire) - CW'(legal_free);
      err_d = illegal_free;

      if (clr_i) begin
         occ_d = '0;
         pos_d = '0;
         cnt_d = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         occ_q <= '0;
         pos_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         pos_q <= pos_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign occ_o   = occ_q;
   assign cnt_o   = cnt_q;
   assign full_o  = (cnt_q == CW'(W));
   assign empty_o = (cnt_q == '0);
   assign err_o   = err_q;

endmodule

// File: tb/tb_e_alloc.sv
// tb/tb_e_alloc.sv - directed self-checking bench for e_alloc with W=16
module tb_e_alloc;

   localparam int W = 16;

   logic        clk;
   logic        arst_n;
   logic        clr_i;
   logic        alloc_vld_o;
   logic [3:0]  alloc_id_o;
   logic        alloc_rdy_i;
   logic        free_vld_i;
   logic [3:0]  free_id_i;
   logic [15:0] occ_o;
   logic [4:0]  cnt_o;
   logic        full_o;
   logic        empty_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   e_alloc #(.W(W), .RADIX_N(4)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .clr_i       (clr_i),
      .alloc_vld_o (alloc_vld_o),
      .alloc_id_o  (alloc_id_o),
      .alloc_rdy_i (alloc_rdy_i),
      .free_vld_i  (free_vld_i),
      .free_id_i   (free_id_i),
      .occ_o       (occ_o),
      .cnt_o       (cnt_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      arst_n      = 1'b0;
      clr_i       = 1'b0;
      alloc_rdy_i = 1'b0;
      free_vld_i  = 1'b0;
      free_id_i   = '0;
      #12;
      chk("rst_occ",   occ_o, 16'h0000);
      chk("rst_cnt",   cnt_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_full",  full_o, 0);
      chk("rst_err",   err_o, 0);
      chk("rst_vld",   alloc_vld_o, 1);
      chk("rst_id",    alloc_id_o, 15);
      arst_n = 1'b1;
      step();

      // allocate every cycle: ids 15 down to 0
      alloc_rdy_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("seq_vld", alloc_vld_o, 1);
         chk("seq_id",  alloc_id_o, 15 - i);
         chk("seq_cnt", cnt_o, i);
         step();
      end
      chk("full_full", full_o, 1);
      chk("full_vld",  alloc_vld_o, 0);
      chk("full_cnt",  cnt_o, 16);
      chk("full_occ",  occ_o, 16'hFFFF);

      // free 9 while full; rdy stays high and is ignored
      free_vld_i = 1'b1;
      free_id_i  = 4'd9;
      step();
      free_vld_i = 1'b0;
      chk("refree_occ", occ_o, 16'hFDFF);
      chk("refree_vld", alloc_vld_o, 1);
      chk("refree_id",  alloc_id_o, 9);
      chk("refree_cnt", cnt_o, 15);
      step();
      chk("realloc_occ",  occ_o, 16'hFFFF);
      chk("realloc_full", full_o, 1);

      // build occ=0x00F0 with pos=4
      alloc_rdy_i = 1'b0;
      clr_i       = 1'b1;
      step();
      clr_i       = 1'b0;
      alloc_rdy_i = 1'b1;
      for (int i = 0; i < 12; i++) step();
      alloc_rdy_i = 1'b0;
      chk("build_occ", occ_o, 16'hFFF0);
      chk("build_cnt", cnt_o, 12);
      for (int k = 15; k >= 8; k--) begin
         free_vld_i = 1'b1;
         free_id_i  = 4'(k);
         step();
      end
      free_vld_i = 1'b0;
      chk("wrap_occ", occ_o, 16'h00F0);
      chk("wrap_cnt", cnt_o, 4);
      alloc_rdy_i = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         chk("wrap_id", alloc_id_o, i);
         step();
      end
      alloc_rdy_i = 1'b0;
      chk("wrap_occ2", occ_o, 16'h00FF);
      chk("wrap_id15", alloc_id_o, 15);
      chk("wrap_cnt2", cnt_o, 8);

      // allocate 15 and legally free 3 together
      alloc_rdy_i = 1'b1;
      free_vld_i  = 1'b1;
      free_id_i   = 4'd3;
      step();
      alloc_rdy_i = 1'b0;
      free_vld_i  = 1'b0;
      chk("simul_occ", occ_o, 16'h80F7);
      chk("simul_cnt", cnt_o, 8);
      chk("simul_err", err_o, 0);
      chk("simul_id",  alloc_id_o, 14);

      // legal free 5, then free 5 again (illegal)
      free_vld_i = 1'b1;
      free_id_i  = 4'd5;
      step();
      chk("free5_occ", occ_o, 16'h80D7);
      chk("free5_err", err_o, 0);
      step();
      free_vld_i = 1'b0;
      chk("ill5_err", err_o, 1);
      chk("ill5_occ", occ_o, 16'h80D7);
      chk("ill5_cnt", cnt_o, 7);
      step();
      chk("ill5_err_drop", err_o, 0);

      // free the slot currently offered
      chk("offer_id", alloc_id_o, 14);
      free_vld_i = 1'b1;
      free_id_i  = alloc_id_o;
      step();
      free_vld_i = 1'b0;
      chk("illoff_err", err_o, 1);
      chk("illoff_occ", occ_o, 16'h80D7);
      step();
      chk("illoff_err_drop", err_o, 0);

      // clear wins over a pending allocate and free
      clr_i       = 1'b1;
      alloc_rdy_i = 1'b1;
      free_vld_i  = 1'b1;
      free_id_i   = 4'd0;
      step();
      clr_i       = 1'b0;
      alloc_rdy_i = 1'b0;
      free_vld_i  = 1'b0;
      chk("clr_occ",   occ_o, 16'h0000);
      chk("clr_cnt",   cnt_o, 0);
      chk("clr_id",    alloc_id_o, 15);
      chk("clr_empty", empty_o, 1);
      chk("clr_err",   err_o, 0);

      // asynchronous reset mid-stream
      alloc_rdy_i = 1'b1;
      step();
      step();
      chk("pre_arst_occ", occ_o, 16'hC000);
      chk("pre_arst_cnt", cnt_o, 2);
      #2;
      arst_n = 1'b0;
      #1;
      chk("arst_occ",   occ_o, 16'h0000);
      chk("arst_cnt",   cnt_o, 0);
      chk("arst_id",    alloc_id_o, 15);
      chk("arst_empty", empty_o, 1);
      alloc_rdy_i = 1'b0;
      #10;
      arst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e_alloc.md
# e_alloc

Round-robin slot allocator built directly downstream of the circular find-first-zero search `e`. It holds a W-entry occupancy vector and a rotating search pointer, and uses `e` to pick the next free slot. It offers the slot to a consumer over a valid/ready handshake and retires slots through a free port. Typical use: tag, credit or buffer-entry allocation, where fair circular reuse of entries is required.

## Interface
Parameters:
- W, 32: number of slots; power of two, W ≥ 4.
- RADIX_N, 4: radix forwarded to `e`; range [4,8].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear of all allocator state.
- alloc_vld_o  out  1  a free slot is offered.
- alloc_id_o  out  $clog2(W)  offered slot index.
- alloc_rdy_i  in  1  consumer accepts the offered slot.
- free_vld_i  in  1  retire a slot.
- free_id_i  in  $clog2(W)  index of the slot to retire.
- occ_o  out  W  occupancy vector; bit k = slot k allocated.
- cnt_o  out  $clog2(W+1)  number of allocated slots.
- full_o  out  1  cnt_o == W.
- empty_o  out  1  cnt_o == 0.
- err_o  out  1  one-cycle pulse: an illegal free was seen in the previous cycle.

## Operation
- State registers:
  - occ (W bits)
  - pos ($clog2(W) bits)
  - cnt
  - err
- `e` is instantiated with x_i = occ and pos_i = pos.
- Combinational outputs from flops:
  - alloc_vld_o = e.any_o
  - alloc_id_o = e.y_enc_o
- Search order is descending from slot pos-1 and wraps from 0 to W-1.
- Allocate handshake: alloc_vld_o & alloc_rdy_i. On that edge:
  - occ[alloc_id_o] is set to 1.
  - pos is loaded with alloc_id_o, so the next search starts one below the slot just granted.
- Legal free: free_vld_i with occ[free_id_i] == 1. On that edge occ[free_id_i] is cleared to 0. pos is unchanged.
- Illegal free: free_vld_i with occ[free_id_i] == 0. This includes freeing the slot offered in the same cycle. Occupancy is unchanged and err is set for one cycle.
- Allocate and legal free in the same cycle target distinct slots by construction. Both updates are applied, and cnt is unchanged.
- cnt rule: cnt_next = cnt + alloc_fire - legal_free. cnt never wraps. An allocate is impossible when full, and a free is illegal when empty.
- clr_i has priority over both ports. On that edge occ = 0, pos = 0, cnt = 0 and err = 0. Handshakes in that cycle are discarded.
- alloc_vld_o may be high while alloc_rdy_i is low. The offered id may change the next cycle if a free lands above it in search order. No stability guarantee is given, because the offer is not a registered request.

## Timing
- Reset values:
  - occ_o = 0, cnt_o = 0, empty_o = 1, full_o = 0, err_o = 0
  - pos = 0, so alloc_vld_o = 1 and alloc_id_o = W-1
- Allocate-to-occupancy latency: 1 cycle. The next offer reflects the update in the following cycle.
- Free-to-reuse latency: 1 cycle. A freed slot is visible to the search on the cycle after free_vld_i.
- err_o asserts the cycle after the illegal free.
- Full: alloc_vld_o = 0 combinationally. alloc_rdy_i is ignored.
- Asynchronous reset mid-operation drops any handshake in flight. There is no recovery of previously allocated ids.
- Critical path: occ/pos flop → `e` → alloc_id_o → occ/pos next-state. The block is not pipelined.

## Structure
- Shared package e_pkg holds:
  - slot index typedef (logic [$clog2(W)-1:0])
  - count typedef
  - function `cnt_w(W)` = $clog2(W+1)
- The single natural sub-module is `e`, reused unchanged.
- Next-state logic, clear priority and error detection live in e_alloc itself.

## Test plan
All scenarios use W=16, RADIX_N=4.
- **Reset, then allocate every cycle:** arst_n pulse, then alloc_rdy_i=1 for 16 cycles → ids 15,14,…,0 in order. full_o=1 on the 17th cycle, alloc_vld_o=0, cnt_o=16.
- **Full, then free and reallocate:** from full, free id 9 → next cycle alloc_vld_o=1 with id 9; occ_o bit 9 clear for exactly one cycle before reallocation.
- **Wrap-around:**
  - Starting state: occ=0x00F0, pos=4; allocate → id 3, then 2, 1, 0.
  - Next allocate → id 15 (descends past 0 and skips occupied slots 4–7 correctly later).
- **Simultaneous events:** allocate (id 15) and free id 3 (occupied) in one cycle → occ bit 15 set, bit 3 cleared, cnt_o unchanged, err_o=0.
- **Illegal free:**
  - Free an unoccupied id 5 → err_o=1 for exactly one cycle and occ_o unchanged.
  - Free of the currently offered id → same response.
- **Clear and asynchronous reset:**
  - clr_i with alloc_rdy_i=1 and a free pending → next cycle occ_o=0, cnt_o=0, alloc_id_o=15, no allocation recorded.
  - arst_n asserted mid-stream → outputs reach reset values without waiting for a clock edge.
